fib_pair_serializer: RTL and testbench
======================================

# fib_pair_serializer

Downstream consumer of the double-rate Fibonacci generator (`fibonacci_2`). Each cycle it accepts one pair of 16-bit terms (`num`, `num2`) through a valid/ready handshake and buffers the pair in a small FIFO. It then emits the terms one per cycle, in order, on a single-word valid/ready output. This bridges the double-rate generator to single-word sinks. It also flags each emitted term that is numerically smaller than the previously emitted term, which is the 16-bit wrap-around point of the sequence.

## Interface

- `DEPTH`, default 4: FIFO capacity in pairs; a power of two, ≥ 2.
- `W`, default 16: term width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `up_valid`  in  1  a pair is offered on `up_num`/`up_num2`.
- `up_ready`  out  1  the block can accept a pair this cycle.
- `up_num`  in  W  earlier term of the pair.
- `up_num2`  in  W  later term of the pair.
- `down_valid`  out  1  `down_data` holds a term.
- `down_ready`  in  1  the sink accepts the term this cycle.
- `down_data`  out  W  emitted term.
- `down_wrap`  out  1  the current term is less than the previously accepted output term.
- `level`  out  $clog2(DEPTH)+1  number of pairs stored, including a partially emitted head pair.

## Operation

- **Storage.** Circular buffer of DEPTH entries, each 2W bits holding {num, num2}.
  - Write pointer and read pointer are each $clog2(DEPTH)+1 bits wide (extra wrap bit).
  - full: pointers are equal except for the MSB.
  - empty: pointers are fully equal.
- **Push.** Occurs when `up_valid && up_ready`.
  - `up_ready = !full`. There is no same-cycle bypass: when full, a push is refused even in a cycle that pops.
- **Half-select register `half`.** Reset value 0.
  - While `half` is 0, `down_data` is the head entry's num.
  - While `half` is 1, `down_data` is the head entry's num2.
- **Output handshake.** An output handshake is `down_valid && down_ready`.
  - On a handshake with `half` = 0: `half` becomes 1 and the entry is not freed.
  - On a handshake with `half` = 1: `half` becomes 0 and the head entry is popped.
- **Output validity.**
  - `down_valid = !empty`.
  - While `down_valid` is 0, `down_data` is 0 and `down_wrap` is 0.
- **Wrap detection.** Register `last` holds the most recently accepted output term; reset value 0.
  - `last` updates to `down_data` on every output handshake.
  - `down_wrap = down_valid && (down_data < last)`, an unsigned compare.
  - `down_wrap` is stable while the output is stalled.
- **Occupancy.** `level = wptr - rptr`, computed modulo with the wrap bit.
  - A head pair whose num has been emitted still counts until its num2 is accepted.
- **Simultaneous push and pop** (not full): both take effect, so `level` is unchanged.
- **Arithmetic.** No arithmetic on data; terms pass through bit-exact.
- **Reset.** Asynchronous assertion clears the pointers, `half` and `last` immediately.
  - Any stored or partially emitted pair is discarded.
  - Deassertion is sampled synchronously with `clk`; the bench must release reset away from the clock edge.

## Timing

- Reset values: `up_ready` = 1, `down_valid` = 0, `down_data` = 0, `down_wrap` = 0, `level` = 0.
- Latency: a pair pushed at edge N gives `down_valid` = 1 with `down_data` = num after edge N, i.e. one cycle.
  - With `down_ready` held high, num appears after edge N and num2 after edge N+1.
- Throughput: one term per cycle out. Sustained input is one pair every 2 cycles; bursts of up to DEPTH pairs are absorbed.
- `up_ready` depends only on registered state. `down_data` and `down_valid` are combinational from registered state only, with no input-to-output combinational path.
- `down_ready` low holds `down_data`, `down_wrap`, `half` and `last` unchanged.

## Test plan

- **Single pair:** after reset, push (1,1) once with `down_ready` = 1.
  - Required: `down_data` 1 then 1 on consecutive cycles, then `down_valid` = 0 and `level` back to 0.
- **Chained with `fibonacci_2`:** the generator drives the up side with `up_valid` = 1 and is stalled when `up_ready` is low.
  - Required: output stream 1,1,2,3,5,8,13,21 with no gaps after the first term, and `down_wrap` = 0 throughout.
- **Fill:** DEPTH = 4, `down_ready` = 0, offer 5 pairs.
  - Required: `up_ready` = 0 after the 4th push and `level` = 4; the 5th pair is accepted only after 2 output handshakes free one entry.
- **Wrap:** push (28657,46368), then (9489,55857), then drain.
  - Required: `down_wrap` = 1 only on the term 9489 and 0 on the other three.
- **Mid-pair stall:** push (5,8) and accept 5, then hold `down_ready` = 0 for 3 cycles.
  - Required: `down_data` = 8 held steady, `level` = 1; after release, 8 is accepted and `level` = 0.
- **Reset mid-operation:** with 3 pairs stored and `half` = 1, pulse `rst` between edges.
  - Required: immediately `level` = 0, `down_valid` = 0 and `up_ready` = 1.
  - Required: after release, the next pushed pair (2,3) emits 2 first with `down_wrap` = 0.

Source files
------------

// File: rtl/fib_pair_serializer.sv
// rtl/fib_pair_serializer.sv - pair FIFO that re-emits {num, num2} terms one per cycle with wrap flag
// Buffers term pairs from a double-rate generator and serializes them with a half-select.

module fib_pair_serializer #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     up_valid,
   output logic                     up_ready,
   input  logic [W-1:0]             up_num,
   input  logic [W-1:0]             up_num2,
   output logic                     down_valid,
   input  logic                     down_ready,
   output logic [W-1:0]             down_data,
   output logic                     down_wrap,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [2*W-1:0] mem_q [DEPTH];
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   logic           half_q, half_d;
   logic [W-1:0]   last_q, last_d;

   logic           full;
   logic           empty;
   logic           push;
   logic           hs;
   logic [2*W-1:0] head;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);

   assign up_ready   = !full;
   assign down_valid = !empty;
   assign push       = up_valid && !full;
   assign hs         = down_valid && down_ready;
   assign head       = mem_q[rptr_q[AW-1:0]];
   assign level      = wptr_q - rptr_q;

   always_comb begin
      down_data = '0;
      if (!empty) begin
         down_data = half_q ? head[W-1:0] : head[2*W-1:W];
      end
   end

   assign down_wrap = down_valid && (down_data < last_q);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      half_d = half_q;
      last_d = last_q;
      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (hs) begin
         last_d = down_data;
         half_d = !half_q;
         // The entry is only freed once its second term has been taken.
         if (half_q) begin
            rptr_d = rptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         half_q <= 1'b0;
         last_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         half_q <= half_d;
         last_q <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= {up_num, up_num2};
      end
   end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// tb/tb_fib_pair_serializer.sv - directed and randomized checks of fib_pair_serializer
module tb_fib_pair_serializer;

   localparam int DEPTH = 4;
   localparam int W     = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_valid;
   logic          up_ready;
   logic [W-1:0]  up_num;
   logic [W-1:0]  up_num2;
   logic          down_valid;
   logic          down_ready;
   logic [W-1:0]  down_data;
   logic          down_wrap;
   logic [2:0]    level;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of stored pairs, which half is next, last accepted term.
   logic [31:0] mq[$];
   logic        mhalf;
   logic [15:0] mlast;
   logic [15:0] got_data[$];
   logic        got_wrap[$];
   logic        last_hs;

   fib_pair_serializer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_num     (up_num),
      .up_num2    (up_num2),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_wrap  (down_wrap),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_data();
      if (mq.size() == 0) return 16'd0;
      return mhalf ? mq[0][15:0] : mq[0][31:16];
   endfunction

   task automatic model_reset();
      mq.delete();
      mhalf = 1'b0;
      mlast = 16'd0;
   endtask

   task automatic check_model(input string tag);
      logic [15:0] d;
      d = exp_data();
      chk({tag, ".up_ready"},   32'(up_ready),   32'(mq.size() < DEPTH));
      chk({tag, ".down_valid"}, 32'(down_valid), 32'(mq.size() != 0));
      chk({tag, ".down_data"},  32'(down_data),  32'(d));
      chk({tag, ".down_wrap"},  32'(down_wrap),  32'((mq.size() != 0) && (d < mlast)));
      chk({tag, ".level"},      32'(level),      32'(mq.size()));
   endtask

   // One clock: drive at the falling edge, check, advance the model, return 1 ns after the rising edge.
   task automatic cycle(input string tag, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic r, output logic pushed);
      logic [15:0] d;
      logic        hs;
      @(negedge clk);
      up_valid = v; up_num = a; up_num2 = b; down_ready = r;
      #1;
      check_model(tag);
      d      = exp_data();
      hs     = r && (mq.size() != 0);
      pushed = v && (mq.size() < DEPTH);
      last_hs = hs;
      if (hs) begin
         got_data.push_back(down_data);
         got_wrap.push_back(down_wrap);
         mlast = d;
         if (mhalf) void'(mq.pop_front());
         mhalf = !mhalf;
      end
      if (pushed) mq.push_back({a, b});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        p;
      logic [15:0] fa, fb, t;
      int          first_seen, gaps, zero_wrap;
      logic [15:0] fib_exp [8];

      fib_exp[0] = 1;  fib_exp[1] = 1;  fib_exp[2] = 2;  fib_exp[3] = 3;
      fib_exp[4] = 5;  fib_exp[5] = 8;  fib_exp[6] = 13; fib_exp[7] = 21;

      rst = 1'b1; up_valid = 1'b0; up_num = '0; up_num2 = '0; down_ready = 1'b0;
      model_reset();
      #12;
      chk("reset.up_ready", 32'(up_ready), 32'd1);
      chk("reset.down_valid", 32'(down_valid), 32'd0);
      chk("reset.down_data", 32'(down_data), 32'd0);
      chk("reset.down_wrap", 32'(down_wrap), 32'd0);
      chk("reset.level", 32'(level), 32'd0);
      rst = 1'b0;

      // Single pair
      got_data.delete(); got_wrap.delete();
      cycle("single0", 1'b1, 16'd1, 16'd1, 1'b1, p);
      chk("single.valid_after_push", 32'(down_valid), 32'd1);
      chk("single.first", 32'(down_data), 32'd1);
      cycle("single1", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("single.second", 32'(down_data), 32'd1);
      cycle("single2", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("single.valid_end", 32'(down_valid), 32'd0);
      chk("single.level_end", 32'(level), 32'd0);
      chk("single.count", 32'(got_data.size()), 32'd2);

      // Chained with a double-rate Fibonacci generator
      got_data.delete(); got_wrap.delete();
      fa = 16'd1; fb = 16'd1; first_seen = 0; gaps = 0;
      for (int i = 0; i < 14; i++) begin
         cycle("chain", 1'b1, fa, fb, 1'b1, p);
         if (last_hs) first_seen = 1;
         else if (first_seen != 0) gaps++;
         if (p) begin
            t  = fa + fb;
            fb = t + fb;
            fa = t;
         end
      end
      for (int i = 0; i < 2 * DEPTH + 2; i++) cycle("chain_drain", 1'b0, 16'd0, 16'd0, 1'b1, p);
      for (int i = 0; i < 8; i++) chk($sformatf("chain.term%0d", i), 32'(got_data[i]), 32'(fib_exp[i]));
      chk("chain.gaps", 32'(gaps), 32'd0);
      zero_wrap = 0;
      foreach (got_wrap[i]) if (got_wrap[i]) zero_wrap++;
      chk("chain.wrap_count", 32'(zero_wrap), 32'd0);

      // Fill with output stalled
      got_data.delete(); got_wrap.delete();
      for (int k = 0; k < 4; k++) cycle("fill", 1'b1, 16'(10 + 2 * k), 16'(11 + 2 * k), 1'b0, p);
      chk("fill.up_ready_full", 32'(up_ready), 32'd0);
      chk("fill.level_full", 32'(level), 32'd4);
      cycle("fill5_stall", 1'b1, 16'd18, 16'd19, 1'b0, p);
      chk("fill.fifth_refused", 32'(p), 32'd0);
      cycle("fill_hs1", 1'b1, 16'd18, 16'd19, 1'b1, p);
      chk("fill.refused_hs1", 32'(p), 32'd0);
      chk("fill.level_hs1", 32'(level), 32'd4);
      cycle("fill_hs2", 1'b1, 16'd18, 16'd19, 1'b1, p);
      chk("fill.refused_on_pop", 32'(p), 32'd0);
      chk("fill.level_hs2", 32'(level), 32'd3);
      cycle("fill_push5", 1'b1, 16'd18, 16'd19, 1'b1, p);
      chk("fill.fifth_accepted", 32'(p), 32'd1);
      for (int i = 0; i < 2 * DEPTH + 2; i++) cycle("fill_drain", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("fill.total_terms", 32'(got_data.size()), 32'd10);
      for (int i = 0; i < 10; i++) chk($sformatf("fill.term%0d", i), 32'(got_data[i]), 32'(10 + i));

      // Wrap detection
      got_data.delete(); got_wrap.delete();
      cycle("wrap_push1", 1'b1, 16'd28657, 16'd46368, 1'b0, p);
      cycle("wrap_push2", 1'b1, 16'd9489, 16'd55857, 1'b0, p);
      for (int i = 0; i < 5; i++) cycle("wrap_drain", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("wrap.count", 32'(got_data.size()), 32'd4);
      chk("wrap.t0", 32'(got_wrap[0]), 32'd0);
      chk("wrap.t1", 32'(got_wrap[1]), 32'd0);
      chk("wrap.t2_9489", 32'(got_data[2]), 32'd9489);
      chk("wrap.t2", 32'(got_wrap[2]), 32'd1);
      chk("wrap.t3", 32'(got_wrap[3]), 32'd0);

      // Mid-pair stall
      got_data.delete(); got_wrap.delete();
      cycle("stall_push", 1'b1, 16'd5, 16'd8, 1'b0, p);
      cycle("stall_take5", 1'b0, 16'd0, 16'd0, 1'b1, p);
      for (int i = 0; i < 3; i++) begin
         cycle("stall_hold", 1'b0, 16'd0, 16'd0, 1'b0, p);
         chk("stall.data", 32'(down_data), 32'd8);
         chk("stall.level", 32'(level), 32'd1);
      end
      cycle("stall_take8", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("stall.level_after", 32'(level), 32'd0);
      chk("stall.second_term", 32'(got_data[1]), 32'd8);

      // Reset mid-operation with half = 1
      for (int k = 0; k < 3; k++) cycle("rst_fill", 1'b1, 16'(100 + k), 16'(200 + k), 1'b0, p);
      cycle("rst_half", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("rst.level_before", 32'(level), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("rst.level", 32'(level), 32'd0);
      chk("rst.down_valid", 32'(down_valid), 32'd0);
      chk("rst.up_ready", 32'(up_ready), 32'd1);
      model_reset();
      #1 rst = 1'b0;
      cycle("rst_push", 1'b1, 16'd2, 16'd3, 1'b0, p);
      chk("rst.first_data", 32'(down_data), 32'd2);
      chk("rst.first_wrap", 32'(down_wrap), 32'd0);
      for (int i = 0; i < 3; i++) cycle("rst_drain", 1'b0, 16'd0, 16'd0, 1'b1, p);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle("rand", 1'($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 3) != 0), p);
      end
      for (int i = 0; i < 2 * DEPTH + 2; i++) cycle("rand_drain", 1'b0, 16'd0, 16'd0, 1'b1, p);
      chk("rand.level_end", 32'(level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
